multicycle_ctrl: RTL and testbench

Main control state machine for the lab5 multicycle MIPS datapath. Sits directly downstream of the instruction register: consumes the latched opcode (Ins_out[31:26]) and produces every datapath strobe and mux select, including the IRWrite that loads the instruction register. Moore FSM with a memory-ready handshake on fetch and data accesses, plus a retired-instruction counter.

---
 rtl/mc_pkg.sv | 64 ++++++
 rtl/multicycle_ctrl_dec.sv | 77 +++++++
 rtl/multicycle_ctrl.sv | 132 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and codes for the multicycle MIPS control FSM.
// States, opcodes, select encodings and the decoded control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic       retire;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Moore output decode for the multicycle control FSM.
// Pure combinational: state (plus memory handshake) to strobes/selects.
module multicycle_ctrl_dec
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       op_ok,
  output ctrl_t      ctrl
);

  // Per-state strobe and select table; unlisted fields stay 0.
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.irwrite   = mem_ready;
        ctrl.pcwrite   = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_BR;
        ctrl.illegal_op = ~op_ok;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.retire    = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.branch    = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src  = PC_JUMP;
        ctrl.pcwrite = 1'b1;
        ctrl.retire  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the lab5 multicycle MIPS datapath.
// Holds state, lw/sw selection latched at decode, and retire counter.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             illegal_op,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q;
  state_t           state_d;
  logic             is_sw_q;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            dec;
  ctrl_t            ctrl;
  logic             op_ok;

  // Zero only matters to the datapath's branch gating.
  logic unused_zero;
  assign unused_zero = Zero;

  assign op_ok = op_legal(Op);

  multicycle_ctrl_dec u_dec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .op_ok     (op_ok),
    .ctrl      (dec)
  );

  // State register; reset lands in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Remember lw vs sw so Op may change after decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   is_sw_q <= 1'b0;
    else if (state_q == S_DECODE) is_sw_q <= (Op == OP_SW);
  end

  // Next-state logic; memory states wait on mem_ready.
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          (Op == OP_LW),
          (Op == OP_SW):    state_d = S_MEMADR;
          (Op == OP_RTYPE): state_d = S_EXEC;
          (Op == OP_ADDI):  state_d = S_ADDIEX;
          (Op == OP_BEQ):   state_d = S_BRANCH;
          (Op == OP_J):     state_d = S_JUMP;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt_q <= '0;
    else if (dec.retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Strobes are held off while reset is asserted.
  always_comb begin
    ctrl = dec;
    if (!rst_n) begin
      ctrl.irwrite    = 1'b0;
      ctrl.pcwrite    = 1'b0;
      ctrl.branch     = 1'b0;
      ctrl.mem_read   = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.reg_write  = 1'b0;
      ctrl.illegal_op = 1'b0;
      ctrl.retire     = 1'b0;
    end
  end

  assign IRWrite     = ctrl.irwrite;
  assign PCWrite     = ctrl.pcwrite;
  assign Branch      = ctrl.branch;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.memto_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSrc       = ctrl.pc_src;
  assign illegal_op  = ctrl.illegal_op;
  assign retire      = ctrl.retire;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, random
// instruction stream against a micro-step model, reset corner.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       irw;
    logic       pcw;
    logic       br;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       ill;
    logic       ret;
  } outs_t;

  typedef struct {
    bit         rst;
    logic [5:0] op;
    bit         mr;
    outs_t      exp;
    int         cnt;
  } vec_t;

  localparam int P_RST  = 0;
  localparam int P_F    = 1;
  localparam int P_D    = 2;
  localparam int P_ILL  = 3;
  localparam int P_MADR = 4;
  localparam int P_MRD  = 5;
  localparam int P_MWB  = 6;
  localparam int P_MWR  = 7;
  localparam int P_EX   = 8;
  localparam int P_AWB  = 9;
  localparam int P_IEX  = 10;
  localparam int P_IWB  = 11;
  localparam int P_BR   = 12;
  localparam int P_J    = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  Op = 6'd0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        IRWrite, PCWrite, Branch, IorD;
  logic        MemRead, MemWrite, RegWrite, RegDst;
  logic        MemtoReg, ALUSrcA, illegal_op, retire;
  logic [1:0]  ALUSrcB, ALUOp, PCSrc;
  logic [31:0] instr_count;

  logic        w_irw, w_pcw, w_br, w_iord;
  logic        w_mrd, w_mwr, w_rw, w_rdst;
  logic        w_m2r, w_srca, w_ill, w_ret;
  logic [1:0]  w_srcb, w_aluop, w_pcsrc;
  logic [2:0]  cnt_w;

  outs_t act, act_w;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero),
    .mem_ready(mem_ready), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .illegal_op(illegal_op), .retire(retire),
    .instr_count(instr_count)
  );

  multicycle_ctrl #(.CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero),
    .mem_ready(mem_ready), .IRWrite(w_irw),
    .PCWrite(w_pcw), .Branch(w_br), .IorD(w_iord),
    .MemRead(w_mrd), .MemWrite(w_mwr),
    .RegWrite(w_rw), .RegDst(w_rdst),
    .MemtoReg(w_m2r), .ALUSrcA(w_srca),
    .ALUSrcB(w_srcb), .ALUOp(w_aluop), .PCSrc(w_pcsrc),
    .illegal_op(w_ill), .retire(w_ret),
    .instr_count(cnt_w)
  );

  assign act = {IRWrite, PCWrite, Branch, IorD, MemRead,
                MemWrite, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, ALUOp, PCSrc,
                illegal_op, retire};
  assign act_w = {w_irw, w_pcw, w_br, w_iord, w_mrd,
                  w_mwr, w_rw, w_rdst, w_m2r, w_srca,
                  w_srcb, w_aluop, w_pcsrc, w_ill, w_ret};

  // Expected outputs of one micro-step of an instruction.
  function automatic outs_t ph_out(int ph, bit mr);
    outs_t o;
    o = '0;
    case (ph)
      P_RST:  o.srcb = 2'b01;
      P_F: begin
        o.mrd = 1; o.srcb = 2'b01;
        o.irw = mr; o.pcw = mr;
      end
      P_D:    o.srcb = 2'b11;
      P_ILL: begin o.srcb = 2'b11; o.ill = 1; end
      P_MADR: begin o.srca = 1; o.srcb = 2'b10; end
      P_MRD:  begin o.iord = 1; o.mrd = 1; end
      P_MWB:  begin o.rw = 1; o.m2r = 1; o.ret = 1; end
      P_MWR:  begin o.iord = 1; o.mwr = 1; o.ret = mr; end
      P_EX:   begin o.srca = 1; o.aluop = 2'b10; end
      P_AWB:  begin o.rdst = 1; o.rw = 1; o.ret = 1; end
      P_IEX:  begin o.srca = 1; o.srcb = 2'b10; end
      P_IWB:  begin o.rw = 1; o.ret = 1; end
      P_BR: begin
        o.srca = 1; o.aluop = 2'b01;
        o.pcsrc = 2'b01; o.br = 1; o.ret = 1;
      end
      P_J:    begin o.pcsrc = 2'b10; o.pcw = 1; o.ret = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
  endfunction

  task automatic chk(string name, logic [63:0] a,
                     logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h",
               name, $time, a, e);
    end
  endtask

  task automatic check_all(outs_t e, int cnt);
    chk("outputs", 64'(act), 64'(e));
    chk("instr_count", 64'(instr_count), 64'(cnt));
    chk("narrow_outputs", 64'(act_w), 64'(e));
    chk("narrow_count", 64'(cnt_w), 64'(cnt % 8));
  endtask

  vec_t vq[$];

  task automatic add(bit r, logic [5:0] op, bit mr,
                     int ph, int cnt);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr;
    v.exp = r ? ph_out(ph, mr) : ph_out(P_RST, 1'b0);
    v.cnt = cnt;
    vq.push_back(v);
  endtask

  initial begin
    int ph[5];
    int n;
    int kind;
    logic [5:0] iop;
    bit mr;
    int waits;
    outs_t e;

    // directed table
    add(0, 6'h23, 1, P_RST, 0);
    add(0, 6'h23, 1, P_RST, 0);
    add(1, 6'h3f, 1, P_F, 0);
    add(1, 6'h23, 1, P_D, 0);
    add(1, 6'h2b, 1, P_MADR, 0);
    add(1, 6'h2b, 0, P_MRD, 0);
    add(1, 6'h00, 1, P_MRD, 0);
    add(1, 6'h00, 1, P_MWB, 0);
    add(1, 6'h23, 1, P_F, 1);
    add(1, 6'h2b, 1, P_D, 1);
    add(1, 6'h23, 1, P_MADR, 1);
    add(1, 6'h23, 0, P_MWR, 1);
    add(1, 6'h23, 0, P_MWR, 1);
    add(1, 6'h23, 1, P_MWR, 1);
    add(1, 6'h11, 1, P_F, 2);
    add(1, 6'h00, 1, P_D, 2);
    add(1, 6'h04, 1, P_EX, 2);
    add(1, 6'h04, 1, P_AWB, 2);
    add(1, 6'h00, 1, P_F, 3);
    add(1, 6'h04, 1, P_D, 3);
    add(1, 6'h02, 1, P_BR, 3);
    add(1, 6'h02, 1, P_F, 4);
    add(1, 6'h02, 1, P_D, 4);
    add(1, 6'h00, 1, P_J, 4);
    add(1, 6'h08, 0, P_F, 5);
    add(1, 6'h08, 0, P_F, 5);
    add(1, 6'h08, 0, P_F, 5);
    add(1, 6'h08, 1, P_F, 5);
    add(1, 6'h08, 1, P_D, 5);
    add(1, 6'h23, 1, P_IEX, 5);
    add(1, 6'h23, 1, P_IWB, 5);
    add(1, 6'h3f, 1, P_F, 6);
    add(1, 6'h3f, 1, P_ILL, 6);
    add(1, 6'h00, 1, P_F, 6);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst;
      Op = vq[i].op;
      mem_ready = vq[i].mr;
      #2;
      check_all(vq[i].exp, vq[i].cnt);
    end

    // random instruction stream against micro-step model
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      kind = int'($urandom_range(0, 6));
      ph[0] = P_F;
      ph[1] = P_D;
      n = 3;
      case (kind)
        0: begin
          iop = 6'h23; ph[2] = P_MADR;
          ph[3] = P_MRD; ph[4] = P_MWB; n = 5;
        end
        1: begin
          iop = 6'h2b; ph[2] = P_MADR;
          ph[3] = P_MWR; n = 4;
        end
        2: begin
          iop = 6'h00; ph[2] = P_EX;
          ph[3] = P_AWB; n = 4;
        end
        3: begin
          iop = 6'h08; ph[2] = P_IEX;
          ph[3] = P_IWB; n = 4;
        end
        4: begin iop = 6'h04; ph[2] = P_BR; end
        5: begin iop = 6'h02; ph[2] = P_J; end
        default: begin
          iop = 6'h3f;
          for (int t = 0; t < 20; t++) begin
            iop = 6'($urandom);
            if (!is_legal(iop)) break;
          end
          if (is_legal(iop)) iop = 6'h3f;
          ph[1] = P_ILL; n = 2;
        end
      endcase
      for (int s = 0; s < n; s++) begin
        waits = 0;
        forever begin
          @(negedge clk);
          rst_n = 1'b1;
          mr = ($urandom_range(0, 3) != 0) || (waits > 8);
          mem_ready = mr;
          if (ph[s] == P_D || ph[s] == P_ILL) Op = iop;
          else Op = 6'($urandom);
          #2;
          e = ph_out(ph[s], mr);
          check_all(e, model_cnt);
          if (e.ret) model_cnt++;
          if (!(ph[s] inside {P_F, P_MRD, P_MWR}) || mr)
            break;
          waits++;
        end
      end
    end

    // reset asserted while waiting in MEMRD
    @(negedge clk);
    mem_ready = 1'b1; Op = 6'h00;
    #2;
    check_all(ph_out(P_F, 1'b1), model_cnt);
    if (ph_out(P_F, 1'b1).ret) model_cnt++;
    @(negedge clk);
    Op = 6'h23;
    #2;
    check_all(ph_out(P_D, 1'b1), model_cnt);
    @(negedge clk);
    Op = 6'h2b;
    #2;
    check_all(ph_out(P_MADR, 1'b1), model_cnt);
    @(negedge clk);
    mem_ready = 1'b0;
    #2;
    check_all(ph_out(P_MRD, 1'b0), model_cnt);
    #1;
    rst_n = 1'b0;
    #1;
    check_all(ph_out(P_RST, 1'b0), 0);
    @(negedge clk);
    mem_ready = 1'b1;
    #2;
    check_all(ph_out(P_RST, 1'b0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    Op = 6'h02;
    #2;
    check_all(ph_out(P_F, 1'b1), 0);
    @(negedge clk);
    #2;
    check_all(ph_out(P_D, 1'b1), 0);
    @(negedge clk);
    #2;
    check_all(ph_out(P_J, 1'b1), 0);
    @(negedge clk);
    #2;
    check_all(ph_out(P_F, 1'b1), 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not end, got running want done");
    $fatal(1, "timeout");
  end

endmodule
